// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Writeback controller driving the write port of the integer register file
// (32 x 32-bit, x0 hardwired to zero). It merges two writeback sources: the
// single-cycle ALU path, which has priority, and the load/store unit path,
// which is buffered in a small circular FIFO. At most one register-file write
// is issued per cycle, and the write is registered. A pending-write
// scoreboard tracks outstanding destinations for issue-stage hazard checks.
//
// Optional feature: define WB_STARVE_GUARD_EN to enable the LSU starvation
// guard. When enabled, alu_ready drops for one cycle after the FIFO head has
// been blocked by the ALU for MAX_WAIT cycles. When not defined, alu_ready is
// tied high and a continuous ALU stream can starve the FIFO indefinitely.
//
// Parameters:
//   FIFO_DEPTH  LSU writeback FIFO entries (power of two, >= 2)
//   MAX_WAIT    blocked cycles before the starvation guard engages
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   alu_valid/ready/rd/data   ALU writeback request and acceptance
//   lsu_valid/ready/rd/data   LSU writeback request; ready = FIFO not full
//   issue_valid, issue_rd     destination of a newly issued instruction
//   rf_we, rf_wa, rf_wd       registered register-file write port
//   pending                   scoreboard, bit i = write to xi outstanding
//   fifo_count                current LSU FIFO occupancy

module regfile_wb_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [4:0]                  alu_rd,
    input  logic [31:0]                 alu_data,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [4:0]                  lsu_rd,
    input  logic [31:0]                 lsu_data,
    input  logic                        issue_valid,
    input  logic [4:0]                  issue_rd,
    output logic                        rf_we,
    output logic [4:0]                  rf_wa,
    output logic [31:0]                 rf_wd,
    output logic [31:0]                 pending,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Reject configurations the circular buffer cannot support: pointer
    // wrap relies on a power-of-two depth, and the guard needs a positive limit.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_param_check
        $error("regfile_wb_ctrl: illegal FIFO_DEPTH or MAX_WAIT");
    end

    logic [4:0]    mem_rd   [FIFO_DEPTH];
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          alu_acc;
    logic          sel_valid;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic          sel_writes;
    logic [31:0]   pending_next;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign lsu_ready  = !fifo_full;
    assign fifo_count = count;

    // A full FIFO refuses a push even if the head leaves in the same cycle,
    // so lsu_ready never depends on the arbitration result.
    assign push    = lsu_valid && !fifo_full;
    assign alu_acc = alu_valid && alu_ready;
    assign pop     = !alu_acc && !fifo_empty;

`ifdef WB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt;

    assign alu_ready = (wait_cnt != WW'(MAX_WAIT));

    // Counts cycles in which a waiting FIFO head loses to the ALU. Once the
    // limit is reached alu_ready drops, the head wins and pops, and the count
    // restarts. Whenever the FIFO is non-empty and nothing pops, the ALU must
    // have won, so the increment needs no further qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (fifo_empty || pop) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end
`else
    assign alu_ready = 1'b1;
`endif

    // Arbitration: an accepted ALU request always wins; otherwise the FIFO
    // head is taken. The selected write is registered onto the RF port below.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_acc) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = mem_rd[rd_ptr];
            sel_data  = mem_data[rd_ptr];
        end
    end

    assign sel_writes = sel_valid && (sel_rd != 5'd0);

    // FIFO storage carries no reset; emptiness is tracked by the pointers
    // and count, so stale contents are never observed after a reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= lsu_rd;
            mem_data[wr_ptr] <= lsu_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth. A simultaneous push
    // and pop leaves the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Registered write port. A selected write to x0 is consumed but never
    // raises rf_we, and address/data hold whenever no write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= sel_writes;
            if (sel_writes) begin
                rf_wa <= sel_rd;
                rf_wd <= sel_data;
            end
        end
    end

    // Scoreboard update. The clear is applied first so that a newly issued
    // writer to the same register keeps its bit set; x0 is never pending.
    always_comb begin
        pending_next = pending;
        if (sel_writes) begin
            pending_next[sel_rd] = 1'b0;
        end
        if (issue_valid && issue_rd != 5'd0) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule
